// File: rtl/axi_delay_counter_mc.sv
// rtl/axi_delay_counter_mc.sv - multi-channel programmable delay counter with AXI4-Lite registers
// Each channel turns a trigger edge or software trigger into a one-cycle pulse after DELAY+1 cycles.
module axi_delay_counter_mc #(
    parameter int NUM_CH             = 4,
    parameter int COUNT_W            = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic [NUM_CH-1:0]             trig_i,
    output logic [NUM_CH-1:0]             pulse_o,
    output logic                          irq
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] INFO_VAL    = 32'(NUM_CH) | (32'(COUNT_W) << 8);

    typedef enum logic { ST_IDLE, ST_COUNT } ch_state_t;

    logic                awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [31:0]         rdata_q;
    logic                gen_q, irq_q;
    logic [NUM_CH-1:0]   irq_status_q, irq_en_q, en_q, periodic_q, pulse_q, trig_prev_q;
    logic [COUNT_W-1:0]  delay_q [NUM_CH];
    logic [COUNT_W-1:0]  count_q [NUM_CH];
    logic [31:0]         fires_q [NUM_CH];
    ch_state_t           state_q [NUM_CH];

    logic [31:0]         wr_addr, rd_addr, rd_val;
    logic                wr_en, rd_en, wr_ok, rd_ok, wr_glb;
    logic [NUM_CH-1:0]   wr_ch, swtrig, trig_evt, active, fire, st_clr;

    // Region 0 holds the globals, region n+1 holds channel n; unaligned accesses are unmapped.
    function automatic logic addr_mapped(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:4] <= 28'(NUM_CH));
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

    assign wr_addr = 32'(S_AXI_AWADDR);
    assign rd_addr = 32'(S_AXI_ARADDR);
    assign wr_en   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en   = arready_q & S_AXI_ARVALID;
    assign wr_ok   = addr_mapped(wr_addr);
    assign rd_ok   = addr_mapped(rd_addr);
    assign wr_glb  = wr_en && wr_ok && (wr_addr[31:4] == 28'd0);
    assign active  = {NUM_CH{gen_q}} & en_q;
    assign st_clr  = (wr_glb && wr_addr[3:2] == 2'd1 && S_AXI_WSTRB[0]) ? S_AXI_WDATA[NUM_CH-1:0] : '0;

    always_comb begin
        wr_ch    = '0;
        swtrig   = '0;
        fire     = '0;
        trig_evt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ch[i]    = wr_en && wr_ok && (wr_addr[31:4] == 28'(i + 1));
            swtrig[i]   = wr_ch[i] && (wr_addr[3:2] == 2'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[2];
            trig_evt[i] = (trig_i[i] & ~trig_prev_q[i]) | swtrig[i];
            fire[i]     = active[i] && (state_q[i] == ST_COUNT) && (count_q[i] == '0);
        end
    end

    always_comb begin
        rd_val = '0;
        if (rd_ok && rd_addr[31:4] == 28'd0) begin
            case (rd_addr[3:2])
                2'd0:    rd_val = {31'd0, gen_q};
                2'd1:    rd_val = 32'(irq_status_q);
                2'd2:    rd_val = 32'(irq_en_q);
                default: rd_val = INFO_VAL;
            endcase
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ok && rd_addr[31:4] == 28'(i + 1)) begin
                case (rd_addr[3:2])
                    2'd0:    rd_val = 32'({periodic_q[i], en_q[i]});
                    2'd1:    rd_val = 32'(delay_q[i]);
                    2'd2:    rd_val = 32'(count_q[i]);
                    default: rd_val = fires_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            gen_q        <= 1'b0;
            irq_q        <= 1'b0;
            irq_status_q <= '0;
            irq_en_q     <= '0;
            en_q         <= '0;
            periodic_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) delay_q[i] <= '0;
        end else begin
            awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= !arready_q && S_AXI_ARVALID && !rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end

            if (wr_glb && S_AXI_WSTRB[0]) begin
                if (wr_addr[3:2] == 2'd0) gen_q    <= S_AXI_WDATA[0];
                if (wr_addr[3:2] == 2'd2) irq_en_q <= S_AXI_WDATA[NUM_CH-1:0];
            end
            // A new expiry overrides a simultaneous W1C on the same bit.
            irq_status_q <= (irq_status_q & ~st_clr) | fire;
            irq_q        <= |(irq_status_q & irq_en_q);

            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ch[i] && wr_addr[3:2] == 2'd0 && S_AXI_WSTRB[0]) begin
                    en_q[i]       <= S_AXI_WDATA[0];
                    periodic_q[i] <= S_AXI_WDATA[1];
                end
                if (wr_ch[i] && wr_addr[3:2] == 2'd1)
                    delay_q[i] <= COUNT_W'(merge_bytes(32'(delay_q[i]), S_AXI_WDATA, S_AXI_WSTRB));
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            trig_prev_q <= '0;
            pulse_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                count_q[i] <= '0;
                fires_q[i] <= '0;
            end
        end else begin
            trig_prev_q <= trig_i;
            pulse_q     <= fire;
            for (int i = 0; i < NUM_CH; i++) begin
                if (fire[i]) fires_q[i] <= fires_q[i] + 32'd1;
                if (!active[i]) begin
                    state_q[i] <= ST_IDLE;
                    count_q[i] <= '0;
                end else if (state_q[i] == ST_IDLE) begin
                    if (trig_evt[i]) begin
                        state_q[i] <= ST_COUNT;
                        count_q[i] <= delay_q[i];
                    end
                end else if (count_q[i] != '0) begin
                    count_q[i] <= count_q[i] - COUNT_W'(1);
                end else if (periodic_q[i]) begin
                    count_q[i] <= delay_q[i];
                end else begin
                    state_q[i] <= ST_IDLE;
                end
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign pulse_o       = pulse_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_axi_delay_counter_mc.sv
// tb/tb_axi_delay_counter_mc.sv - directed self-checking bench for axi_delay_counter_mc
module tb_axi_delay_counter_mc;
    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NUM_CH-1:0] trig = '0, pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pcnt [NUM_CH];
    int ptime [NUM_CH][16];
    int irq_rise = -1;

    axi_delay_counter_mc #(.NUM_CH(NUM_CH), .COUNT_W(32), .C_S_AXI_ADDR_WIDTH(8)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .trig_i(trig), .pulse_o(pulse), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // At a negedge, cyc equals the number of the rising edge that opened the current cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (pulse[i]) begin
                if (pcnt[i] < 16) ptime[i][pcnt[i]] = cyc;
                pcnt[i]++;
            end
        end
        if (irq && irq_rise < 0) irq_rise = cyc;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        for (int i = 0; i < NUM_CH; i++) pcnt[i] = 0;
    endtask

    task automatic wait_to(input int t);
        int n = 0;
        @(negedge clk);
        while (cyc < t && n < 2000) begin @(negedge clk); n++; end
    endtask

    // Handshake edge h is two edges after the negedge the task starts on.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r, output int h);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!awready) begin errors++; $display("FAIL aw_timeout addr %h", a); end
        @(posedge clk); #1;
        h = cyc; awvalid = 0; wvalid = 0;
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_latency got %b exp 1", bvalid); end
        r = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = 1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!arready) begin errors++; $display("FAIL ar_timeout addr %h", a); end
        @(posedge clk); #1;
        arvalid = 0;
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_latency got %b exp 1", rvalid); end
        d = rdata; r = rresp;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  zaddr [11];
        zaddr = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h44, 8'h48, 8'h4C};
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0)
            begin errors++; $display("FAIL reset_handshake got %b exp 0", {awready, wready, bvalid, arready, rvalid}); end
        checks++;
        if ({bresp, rresp, rdata} !== 36'd0)
            begin errors++; $display("FAIL reset_resp_data got %h exp 0", {bresp, rresp, rdata}); end
        checks++;
        if ({pulse, irq} !== 5'd0) begin errors++; $display("FAIL reset_pulse_irq got %b exp 0", {pulse, irq}); end
        rst = 0;
        axi_read(8'h0C, d, r);
        checks++;
        if (d !== 32'h0000_2004 || r !== 2'b00) begin errors++; $display("FAIL info got %h/%0d exp 00002004/0", d, r); end
        foreach (zaddr[k]) begin
            axi_read(zaddr[k], d, r);
            checks++;
            if (d !== 32'd0 || r !== 2'b00)
                begin errors++; $display("FAIL reset_reg_%h got %h/%0d exp 0/0", zaddr[k], d, r); end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic [1:0]  r;
        int h, t;
        axi_write(8'h00, 32'h1, 4'hF, r, h);
        axi_write(8'h10, 32'h1, 4'hF, r, h);
        axi_write(8'h14, 32'd5, 4'hF, r, h);
        clear_log();
        @(posedge clk); #1; trig[0] = 1; t = cyc + 1;
        @(posedge clk); #1; trig[0] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1; trig[0] = 1;
        @(posedge clk); #1; trig[0] = 0;
        wait_to(t + 12);
        checks++;
        if (pcnt[0] !== 1) begin errors++; $display("FAIL oneshot_count got %0d exp 1", pcnt[0]); end
        checks++;
        if (ptime[0][0] !== t + 6) begin errors++; $display("FAIL oneshot_time got %0d exp %0d", ptime[0][0], t + 6); end
        checks++;
        if (pcnt[1] + pcnt[2] + pcnt[3] !== 0) begin errors++; $display("FAIL oneshot_other_ch got %0d exp 0", pcnt[1] + pcnt[2] + pcnt[3]); end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status got %h exp 1", d); end
        axi_read(8'h1C, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL oneshot_fires got %h exp 1", d); end
        axi_read(8'h18, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL oneshot_count_reg got %h exp 0", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq got %b exp 0", irq); end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        logic [1:0]  r;
        int h, h2, n_exp;
        axi_write(8'h24, 32'd2, 4'hF, r, h);
        axi_write(8'h20, 32'h3, 4'hF, r, h);
        clear_log();
        axi_write(8'h20, 32'h7, 4'hF, r, h);
        axi_read(8'h20, d, r);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL cfg_swtrig_readback got %h exp 3", d); end
        wait_to(h + 10);
        axi_write(8'h20, 32'h2, 4'hF, r, h2);
        wait_to(h2 + 12);
        n_exp = (h2 - h) / 3;
        checks++;
        if (pcnt[1] !== n_exp) begin errors++; $display("FAIL periodic_count got %0d exp %0d", pcnt[1], n_exp); end
        for (int k = 0; k < n_exp && k < 16; k++) begin
            checks++;
            if (ptime[1][k] !== h + 3 * (k + 1))
                begin errors++; $display("FAIL periodic_time_%0d got %0d exp %0d", k, ptime[1][k], h + 3 * (k + 1)); end
        end
        axi_read(8'h28, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL periodic_count_reg got %h exp 0", d); end
        axi_read(8'h2C, d, r);
        checks++;
        if (d !== 32'(n_exp)) begin errors++; $display("FAIL periodic_fires got %h exp %h", d, n_exp); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [1:0]  r;
        int h, w, f;
        axi_write(8'h04, 32'h3, 4'hF, r, h);
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h exp 0", d); end
        axi_write(8'h08, 32'h2, 4'hF, r, h);
        irq_rise = -1;
        axi_write(8'h10, 32'h5, 4'hF, r, h);
        wait_to(h + 9);
        checks++;
        if (irq_rise !== -1) begin errors++; $display("FAIL irq_masked got rise %0d exp none", irq_rise); end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL masked_status got %h exp 1", d); end
        axi_write(8'h24, 32'd10, 4'hF, r, h);
        axi_write(8'h20, 32'h1, 4'hF, r, h);
        axi_write(8'h20, 32'h5, 4'hF, r, h);
        f = h + 11;
        wait_to(f - 3);
        axi_write(8'h04, 32'h2, 4'hF, r, w);
        checks++;
        if (w !== f) begin errors++; $display("FAIL clear_alignment got %0d exp %0d", w, f); end
        wait_to(f + 3);
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL set_wins got %h exp 3", d); end
        checks++;
        if (irq_rise !== f + 1) begin errors++; $display("FAIL irq_latency got %0d exp %0d", irq_rise, f + 1); end
        axi_write(8'h04, 32'h2, 4'hF, r, h);
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL w1c_bit1 got %h exp 1", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear got %b exp 0", irq); end
    endtask

    task automatic test_wstrb_and_resp();
        logic [31:0] d;
        logic [1:0]  r;
        int h;
        axi_write(8'h34, 32'hFFFF_FFFF, 4'b0001, r, h);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL wstrb_bresp got %0d exp 0", r); end
        axi_read(8'h34, d, r);
        checks++;
        if (d !== 32'h0000_00FF) begin errors++; $display("FAIL wstrb_delay got %h exp 000000ff", d); end
        axi_write(8'h0C, 32'h0, 4'hF, r, h);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL ro_write_bresp got %0d exp 0", r); end
        axi_read(8'h0C, d, r);
        checks++;
        if (d !== 32'h0000_2004) begin errors++; $display("FAIL ro_write_info got %h exp 00002004", d); end
        axi_write(8'hFC, 32'h1, 4'hF, r, h);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL unmapped_bresp got %0d exp 2", r); end
        axi_write(8'h50, 32'h1, 4'hF, r, h);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL ch4_bresp got %0d exp 2", r); end
        axi_read(8'h50, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL ch4_read got %h/%0d exp 0/2", d, r); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        axi_read(8'h0C, d, r);
        @(negedge clk);
        araddr = 8'hFC; arvalid = 1; rready = 0; n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1; arvalid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0)
                begin errors++; $display("FAIL rstall_%0d got %b/%0d/%h exp 1/2/0", k, rvalid, rresp, rdata); end
        end
        rready = 1;
        @(posedge clk); #1; rready = 0;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_release got %b exp 0", rvalid); end
        @(negedge clk);
        awaddr = 8'hFC; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0; n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1; awvalid = 0; wvalid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0)
                begin errors++; $display("FAIL bstall_%0d got %b/%0d/%b exp 1/2/0", k, bvalid, bresp, awready); end
        end
        bready = 1;
        @(posedge clk); #1; bready = 0;
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_release got %b exp 0", bvalid); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        logic [1:0]  r;
        int h;
        axi_write(8'h34, 32'd20, 4'hF, r, h);
        axi_write(8'h30, 32'h1, 4'hF, r, h);
        clear_log();
        axi_write(8'h30, 32'h5, 4'hF, r, h);
        wait_to(h + 5);
        rst = 1;
        #1;
        checks++;
        if ({pulse, irq, bvalid, rvalid} !== 7'd0) begin errors++; $display("FAIL async_reset got %b exp 0", {pulse, irq, bvalid, rvalid}); end
        repeat (2) @(negedge clk);
        rst = 0;
        wait_to(h + 40);
        checks++;
        if (pcnt[2] !== 0) begin errors++; $display("FAIL reset_no_pulse got %0d exp 0", pcnt[2]); end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
        axi_read(8'h38, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 0", d); end
        axi_read(8'h30, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_cfg got %h exp 0", d); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_oneshot();
        test_periodic();
        test_irq();
        test_wstrb_and_resp();
        test_backpressure();
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
